// File: rtl/task_dispatcher_pkg.sv
// Shared definitions for the master-to-worker task dispatcher: FSM encoding and default sizing,
// so the multicore top and the master agree on widths.
package task_dispatcher_pkg;

  localparam int unsigned NUM_CORES_DEF = 61;
  localparam int unsigned CORE_W_DEF    = 6;
  localparam int unsigned DATA_W_DEF    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/task_dispatcher_onehot_dec.sv
// Core index decoder: turns a core index plus enable into a one-hot core vector.
module core_onehot_dec #(
  parameter int unsigned NUM_CORES = 61,
  parameter int unsigned CORE_W    = 6
) (
  input  logic [CORE_W-1:0]    i_idx,
  input  logic                 i_en,
  output logic [NUM_CORES-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      if (i_en && (i_idx == CORE_W'(i))) o_onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/task_dispatcher.sv
// Walks cores 0..NUM_CORES-1 for one master command and hands each enabled core
// (base + i*stride, arg) over a one-hot valid/ack handshake.
module task_dispatcher
  import task_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_CORES = NUM_CORES_DEF,
  parameter int unsigned CORE_W    = CORE_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [DATA_W-1:0]    cmd_base,
  input  logic [DATA_W-1:0]    cmd_stride,
  input  logic [DATA_W-1:0]    cmd_arg,
  input  logic [NUM_CORES-1:0] cmd_mask,
  output logic [NUM_CORES-1:0] task_valid,
  output logic [DATA_W-1:0]    task_val_1,
  output logic [DATA_W-1:0]    task_val_2,
  input  logic [NUM_CORES-1:0] task_ack,
  output logic [CORE_W-1:0]    cur_core,
  output logic                 busy,
  output logic                 done,
  output logic [CORE_W:0]      issued_count
);

  localparam int unsigned      CNT_W     = CORE_W + 1;
  localparam logic [CORE_W-1:0] LAST_CORE = CORE_W'(NUM_CORES - 1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [DATA_W-1:0]    r_acc;
  logic [DATA_W-1:0]    r_stride;
  logic [DATA_W-1:0]    r_arg;
  logic [DATA_W-1:0]    r_val_1;
  logic [DATA_W-1:0]    r_val_2;
  logic [NUM_CORES-1:0] r_mask;
  logic [NUM_CORES-1:0] r_task_valid;
  logic [CORE_W-1:0]    r_cur;
  logic [CNT_W-1:0]     r_issued;
  logic                 r_busy;
  logic                 r_done;

  logic [NUM_CORES-1:0] w_sel;
  logic [NUM_CORES-1:0] w_valid_nxt;
  logic                 w_accept;
  logic                 w_cur_en;
  logic                 w_offered;
  logic                 w_ack_hit;
  logic                 w_advance;
  logic                 w_last;
  logic                 w_load_vals;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;

  core_onehot_dec #(
    .NUM_CORES (NUM_CORES),
    .CORE_W    (CORE_W)
  ) u_core_dec (
    .i_idx    (r_cur),
    .i_en     (1'b1),
    .o_onehot (w_sel)
  );

  assign cmd_ready = (r_state == ST_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_cur_en  = |(w_sel & r_mask);
  assign w_offered = |r_task_valid;
  // Ack only counts for the visited core and only while its task is on the bus.
  assign w_ack_hit = w_offered && (|(w_sel & task_ack));
  assign w_advance = (r_state == ST_ISSUE) && (!w_cur_en || w_ack_hit);
  assign w_last    = (r_cur == LAST_CORE);

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (w_advance && w_last) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered handshake and status outputs.
  always_comb begin
    w_valid_nxt = '0;
    w_load_vals = 1'b0;
    if (r_state == ST_ISSUE) begin
      w_valid_nxt = r_task_valid;
      if (w_ack_hit) begin
        w_valid_nxt = '0;
      end else if (w_cur_en && !w_offered) begin
        w_valid_nxt = w_sel;
        w_load_vals = 1'b1;
      end
    end
    w_busy_nxt = (w_state_nxt == ST_ISSUE);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  // Datapath and registered outputs; acc advances on skips too so val_1 tracks base + i*stride.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_acc        <= '0;
      r_stride     <= '0;
      r_arg        <= '0;
      r_val_1      <= '0;
      r_val_2      <= '0;
      r_mask       <= '0;
      r_task_valid <= '0;
      r_cur        <= '0;
      r_issued     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_task_valid <= w_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      if (w_load_vals) begin
        r_val_1 <= r_acc;
        r_val_2 <= r_arg;
      end
      if (w_accept) begin
        r_acc    <= cmd_base;
        r_stride <= cmd_stride;
        r_arg    <= cmd_arg;
        r_mask   <= cmd_mask;
        r_cur    <= '0;
        r_issued <= '0;
      end else if (w_advance) begin
        r_acc <= r_acc + r_stride;
        if (!w_last)   r_cur    <= r_cur + CORE_W'(1);
        if (w_ack_hit) r_issued <= r_issued + CNT_W'(1);
      end
    end
  end

  assign task_valid   = r_task_valid;
  assign task_val_1   = r_val_1;
  assign task_val_2   = r_val_2;
  assign cur_core     = r_cur;
  assign busy         = r_busy;
  assign done         = r_done;
  assign issued_count = r_issued;

endmodule

// File: tb/tb_task_dispatcher.sv
// Scoreboard bench for task_dispatcher: expected hand-offs queued at command time, popped on each
// valid&ack handshake; status outputs checked directly.
module tb_task_dispatcher;

  localparam int unsigned NC = 61;
  localparam int unsigned CW = 6;
  localparam int unsigned DW = 32;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_base;
  logic [DW-1:0] cmd_stride;
  logic [DW-1:0] cmd_arg;
  logic [NC-1:0] cmd_mask;
  logic [NC-1:0] task_valid;
  logic [DW-1:0] task_val_1;
  logic [DW-1:0] task_val_2;
  logic [NC-1:0] task_ack;
  logic [CW-1:0] cur_core;
  logic          busy;
  logic          done;
  logic [CW:0]   issued_count;

  typedef struct {
    int          idx;
    logic [31:0] v1;
    logic [31:0] v2;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  int   cyc_cnt  = 0;

  task_dispatcher #(
    .NUM_CORES (NC),
    .CORE_W    (CW),
    .DATA_W    (DW)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_base     (cmd_base),
    .cmd_stride   (cmd_stride),
    .cmd_arg      (cmd_arg),
    .cmd_mask     (cmd_mask),
    .task_valid   (task_valid),
    .task_val_1   (task_val_1),
    .task_val_2   (task_val_2),
    .task_ack     (task_ack),
    .cur_core     (cur_core),
    .busy         (busy),
    .done         (done),
    .issued_count (issued_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc_cnt++;
  endtask

  // Handshake monitor: inputs change just after posedge, so negedge sees what the next edge samples.
  always @(negedge Clk) begin
    if (Reset) begin
      if ((task_valid & task_ack) != '0) begin
        if (exp_q.size() == 0) begin
          chk_eq("unexpected_task", 64'(task_valid), 64'd0);
        end else begin
          exp_t          e;
          logic [NC-1:0] oh;
          e  = exp_q.pop_front();
          oh = '0;
          oh[e.idx] = 1'b1;
          chk_eq($sformatf("task_valid_core%0d", e.idx), 64'(task_valid), 64'(oh));
          chk_eq($sformatf("val_1_core%0d", e.idx), 64'(task_val_1), 64'(e.v1));
          chk_eq($sformatf("val_2_core%0d", e.idx), 64'(task_val_2), 64'(e.v2));
        end
      end
      if (done) n_done++;
    end
  end

  task automatic issue_cmd(input logic [DW-1:0] base, input logic [DW-1:0] stride,
                           input logic [DW-1:0] arg, input logic [NC-1:0] mask);
    exp_t e;
    chk_eq("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < int'(NC); i++) begin
      if (mask[i]) begin
        e.idx = i;
        e.v1  = base + stride * DW'(i);
        e.v2  = arg;
        exp_q.push_back(e);
      end
    end
    cmd_valid  = 1'b1;
    cmd_base   = base;
    cmd_stride = stride;
    cmd_arg    = arg;
    cmd_mask   = mask;
    tick();
    cmd_valid  = 1'b0;
    cyc_cnt    = 1;
  endtask

  // Waits (bounded) for done, then checks count, latency, single pulse and return to IDLE.
  task automatic finish_cmd(input string tag, input int exp_cycles, input int exp_issued);
    int d0;
    d0 = n_done;
    while (!done && cyc_cnt < 1000) tick();
    if (!done) begin
      chk_eq({tag, "_done_timeout"}, 64'd0, 64'd1);
      return;
    end
    if (exp_cycles > 0) chk_eq({tag, "_done_cycle"}, 64'(cyc_cnt), 64'(exp_cycles));
    chk_eq({tag, "_issued_count"}, 64'(issued_count), 64'(exp_issued));
    chk_eq({tag, "_pending_tasks"}, 64'(exp_q.size()), 64'd0);
    chk_eq({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    tick();
    chk_eq({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    chk_eq({tag, "_cmd_ready_after"}, 64'(cmd_ready), 64'd1);
    chk_eq({tag, "_done_pulses"}, 64'(n_done), 64'(d0 + 1));
    chk_eq({tag, "_issued_hold"}, 64'(issued_count), 64'(exp_issued));
  endtask

  initial begin
    logic [NC-1:0] all_ones;
    logic [NC-1:0] ack_pat;
    int            w;
    all_ones   = '1;
    Reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_base   = '0;
    cmd_stride = '0;
    cmd_arg    = '0;
    cmd_mask   = '0;
    task_ack   = '0;

    // Reset state.
    repeat (3) tick();
    chk_eq("rst_task_valid", 64'(task_valid), 64'd0);
    chk_eq("rst_val_1", 64'(task_val_1), 64'd0);
    chk_eq("rst_val_2", 64'(task_val_2), 64'd0);
    chk_eq("rst_cur_core", 64'(cur_core), 64'd0);
    chk_eq("rst_busy", 64'(busy), 64'd0);
    chk_eq("rst_done", 64'(done), 64'd0);
    chk_eq("rst_issued", 64'(issued_count), 64'd0);
    chk_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    Reset = 1'b1;
    tick();
    chk_eq("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk_eq("post_rst_busy", 64'(busy), 64'd0);

    // All cores, ack held high: 2 cycles per core.
    task_ack = '1;
    issue_cmd(32'h100, 32'd4, 32'hA5, all_ones);
    chk_eq("full_busy", 64'(busy), 64'd1);
    chk_eq("full_cmd_ready_busy", 64'(cmd_ready), 64'd0);
    finish_cmd("full", 2 * int'(NC) + 1, int'(NC));
    chk_eq("full_val_1_hold", 64'(task_val_1), 64'h1F0);

    // Sparse mask, cores 0 and 2.
    issue_cmd(32'd10, 32'd3, 32'h33, NC'(5));
    finish_cmd("sparse", int'(NC) + 3, 2);

    // Empty mask: no valid ever, done NUM_CORES+1 cycles after accept.
    issue_cmd(32'h1234, 32'd7, 32'h9, '0);
    finish_cmd("empty", int'(NC) + 1, 0);

    // Foreign ack ignored; core 0 acks late and the offer stays stable meanwhile.
    task_ack = NC'(2);
    issue_cmd(32'h40, 32'h10, 32'h77, NC'(3));
    w = 0;
    while (task_valid[0] !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk_eq("stall_offer_seen", 64'(task_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_eq("stall_valid_hold", 64'(task_valid), 64'd1);
      chk_eq("stall_val_1_hold", 64'(task_val_1), 64'h40);
      chk_eq("stall_issued", 64'(issued_count), 64'd0);
    end
    task_ack = NC'(1);
    tick();
    chk_eq("stall_valid_drop", 64'(task_valid), 64'd0);
    chk_eq("stall_advance", 64'(cur_core), 64'd1);
    chk_eq("stall_val_1_kept", 64'(task_val_1), 64'h40);
    task_ack = '1;
    finish_cmd("stall", 0, 2);

    // Accumulator wrap, plus a command pulsed while busy that must be dropped.
    issue_cmd(32'hFFFF_FFFC, 32'd4, 32'h5, NC'(3));
    cmd_valid  = 1'b1;
    cmd_base   = 32'hDEAD;
    cmd_stride = 32'd1;
    cmd_mask   = '1;
    chk_eq("wrap_ready_while_busy", 64'(cmd_ready), 64'd0);
    tick();
    cmd_valid = 1'b0;
    finish_cmd("wrap", int'(NC) + 3, 2);
    repeat (2) tick();
    chk_eq("wrap_no_queued_cmd", 64'(busy), 64'd0);

    // Reset while core 7 is offered (core 7 withholds ack).
    ack_pat = '1;
    ack_pat[7] = 1'b0;
    task_ack = ack_pat;
    issue_cmd(32'h0, 32'd1, 32'h66, all_ones);
    w = 0;
    while (task_valid[7] !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    chk_eq("midrst_core7_offered", 64'(task_valid), 64'(NC'(1) << 7));
    w = n_done;
    Reset = 1'b0;
    #1;
    chk_eq("midrst_valid_async", 64'(task_valid), 64'd0);
    chk_eq("midrst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    repeat (2) begin
      tick();
      chk_eq("midrst_no_done", 64'(done), 64'd0);
    end
    chk_eq("midrst_issued_clr", 64'(issued_count), 64'd0);
    Reset    = 1'b1;
    task_ack = '1;
    tick();
    chk_eq("midrst_no_done_pulse", 64'(n_done), 64'(w));
    issue_cmd(32'h500, 32'd1, 32'h11, NC'(1));
    chk_eq("restart_core0", 64'(cur_core), 64'd0);
    finish_cmd("restart", int'(NC) + 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
